// File: rtl/search_ctrl.sv
// Search controller: sequences an external searcher through reset/run/ack
// handshakes and collects match addresses into a first-word-fall-through FIFO.
module search_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1024,
  parameter logic [7:0]  NO_MATCH   = 8'hFF
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic                          cmd_start,
  input  logic [7:0]                    cmd_p,
  input  logic [7:0]                    cmd_pl,
  input  logic [7:0]                    cmd_b,
  input  logic [7:0]                    cmd_bl,
  output logic [7:0]                    p,
  output logic [7:0]                    pl,
  output logic [7:0]                    b,
  output logic [7:0]                    bl,
  output logic                          s_reset,
  output logic                          activate,
  input  logic                          done,
  input  logic [7:0]                    found,
  input  logic                          res_rd,
  output logic [7:0]                    res_data,
  output logic                          res_empty,
  output logic [$clog2(FIFO_DEPTH):0]   res_count,
  output logic                          busy,
  output logic                          cmd_done,
  output logic                          overflow,
  output logic                          timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_ACT    = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [WW-1:0] r_wait;
  logic [7:0]    r_p, r_pl, r_b, r_bl;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow, r_timeout;
  logic          w_accept, w_push, w_pop, w_full, w_set_ovf, w_set_to;

  assign w_accept = (r_state == S_IDLE) && cmd_start;
  assign w_full   = (r_count == FULL_CNT);
  assign w_pop    = res_rd && (r_count != '0);

  always_comb begin
    w_next    = r_state;
    w_push    = 1'b0;
    w_set_ovf = 1'b0;
    w_set_to  = 1'b0;
    case (r_state)
      S_IDLE:   if (cmd_start) w_next = S_RST;
      S_RST:    w_next = S_SETTLE;
      S_SETTLE: w_next = S_ACT;
      S_ACT: begin
        if (done) begin
          if (found == NO_MATCH) begin
            w_next = S_FIN;
          end else if (!w_full) begin
            w_push = 1'b1;
            w_next = S_ACK;
          end else begin
            w_set_ovf = 1'b1;
            w_next    = S_FIN;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_set_to = 1'b1;
          w_next   = S_FIN;
        end
      end
      S_ACK: begin
        if (!done) begin
          w_next = S_ACT;
        end else if (r_wait == WAIT_LAST) begin
          w_set_to = 1'b1;
          w_next   = S_FIN;
        end
      end
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait     <= '0;
      r_p        <= '0;
      r_pl       <= '0;
      r_b        <= '0;
      r_bl       <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Any state change restarts the wait count; only ACT/ACK accumulate.
      if (w_next != r_state)
        r_wait <= '0;
      else if (r_state == S_ACT || r_state == S_ACK)
        r_wait <= r_wait + WW'(1);
      else
        r_wait <= '0;

      if (w_accept) begin
        r_p        <= cmd_p;
        r_pl       <= cmd_pl;
        r_b        <= cmd_b;
        r_bl       <= cmd_bl;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
        r_timeout  <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        if (w_set_ovf) r_overflow <= 1'b1;
        if (w_set_to)  r_timeout  <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= found;
  end

  assign p         = r_p;
  assign pl        = r_pl;
  assign b         = r_b;
  assign bl        = r_bl;
  assign s_reset   = reset || (r_state == S_RST);
  assign activate  = (r_state == S_ACT);
  assign busy      = (r_state != S_IDLE);
  assign cmd_done  = (r_state == S_FIN);
  assign overflow  = r_overflow;
  assign timeout   = r_timeout;
  assign res_data  = r_mem[r_rd_ptr];
  assign res_empty = (r_count == '0);
  assign res_count = r_count;

endmodule

// File: tb/tb_search_ctrl.sv
// Bench for search_ctrl: a behavioural searcher feeds random match lists and
// the collected results are compared against the list, in order.
module tb_search_ctrl;

  localparam int unsigned FD = 8;
  localparam int unsigned TO = 16;
  localparam logic [7:0]  NM = 8'hFF;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_start = 1'b0;
  logic [7:0] cmd_p = '0, cmd_pl = '0, cmd_b = '0, cmd_bl = '0;
  logic [7:0] p, pl, b, bl;
  logic       s_reset, activate;
  logic       done = 1'b0;
  logic [7:0] found = '0;
  logic       res_rd = 1'b0;
  logic [7:0] res_data;
  logic       res_empty;
  logic [3:0] res_count;
  logic       busy, cmd_done, overflow, timeout;

  search_ctrl #(.FIFO_DEPTH(FD), .TIMEOUT(TO), .NO_MATCH(NM)) dut (
    .CLK100MHZ(clk), .reset(reset), .cmd_start(cmd_start),
    .cmd_p(cmd_p), .cmd_pl(cmd_pl), .cmd_b(cmd_b), .cmd_bl(cmd_bl),
    .p(p), .pl(pl), .b(b), .bl(bl), .s_reset(s_reset), .activate(activate),
    .done(done), .found(found), .res_rd(res_rd), .res_data(res_data),
    .res_empty(res_empty), .res_count(res_count), .busy(busy),
    .cmd_done(cmd_done), .overflow(overflow), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int n_srst  = 0;

  logic [7:0] m_arr [$];
  logic [7:0] got_q [$];
  bit         never_done = 1'b0;
  int         rd_mode = 0;
  bit         pp_chk = 1'b0;
  int         idx = 0, lat = 0, dl = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Searcher model and result reader, both acting on the falling edge.
  always @(negedge clk) begin
    res_rd = 1'b0;
    if (pp_chk) begin
      chk("pop_push_count", res_count, 3);
      pp_chk = 1'b0;
    end
    if (cmd_done) n_done++;
    if (s_reset)  n_srst++;

    if (s_reset) begin
      done = 1'b0;
      idx  = 0;
      lat  = $urandom_range(0, 3);
      dl   = $urandom_range(0, 2);
    end else if (done) begin
      if (!activate) begin
        if (dl == 0) begin
          done = 1'b0;
          idx++;
          dl = $urandom_range(0, 2);
        end else dl--;
      end
    end else if (activate && !never_done) begin
      if (lat == 0) begin
        done  = 1'b1;
        found = (idx < m_arr.size()) ? m_arr[idx] : NM;
        lat   = $urandom_range(0, 3);
        if (rd_mode == 2 && idx < m_arr.size() && res_count == 4'd3) begin
          got_q.push_back(res_data);
          res_rd = 1'b1;
          pp_chk = 1'b1;
        end
      end else lat--;
    end

    if (!res_rd) begin
      if ((rd_mode == 1 && $urandom_range(0, 2) == 0) || rd_mode == 3) begin
        res_rd = 1'b1;
        if (!res_empty) got_q.push_back(res_data);
      end
    end
  end

  task automatic start_cmd(input logic [7:0] cp, cpl, cb, cbl);
    @(negedge clk);
    cmd_p = cp; cmd_pl = cpl; cmd_b = cb; cmd_bl = cbl;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic fill_random(input int n);
    m_arr.delete();
    for (int i = 0; i < n; i++) m_arr.push_back(8'($urandom_range(0, 254)));
  endtask

  task automatic run_search(input logic [7:0] cp, cpl, cb, cbl,
                            input int rmode, input bit busy_start);
    int  d0, s0, nexp;
    bit  seen;
    d0 = n_done; s0 = n_srst; seen = 1'b0;
    nexp = (m_arr.size() < FD) ? m_arr.size() : FD;
    got_q.delete();
    rd_mode = rmode;
    start_cmd(cp, cpl, cb, cbl);
    if (busy_start) begin
      repeat (2) @(negedge clk);
      chk("busy_during_search", busy, 1);
      cmd_b = cb ^ 8'h5A; cmd_p = cp ^ 8'h33;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (cmd_done) begin seen = 1'b1; break; end
    end
    chk("cmd_done_seen", seen, 1);
    rd_mode = 0;
    @(negedge clk);
    chk("cmd_done_pulses", n_done - d0, 1);
    chk("s_reset_pulses", n_srst - s0, 1);
    chk("activate_after_fin", activate, 0);
    chk("busy_after_fin", busy, 0);
    chk("overflow", overflow, (m_arr.size() > FD) ? 1 : 0);
    chk("timeout_flag", timeout, 0);
    chk("res_count", res_count, nexp - got_q.size());
    chk("p_hold", p, cp);
    chk("pl_hold", pl, cpl);
    chk("b_hold", b, cb);
    chk("bl_hold", bl, cbl);
    if (got_q.size() < nexp) chk("head", res_data, m_arr[got_q.size()]);
    rd_mode = 3;
    for (int i = 0; i < 2 * FD + 4; i++) begin
      @(negedge clk);
      if (res_empty) break;
    end
    repeat (2) @(negedge clk);
    rd_mode = 0;
    @(negedge clk);
    chk("empty_read_count", res_count, 0);
    chk("empty_read_flag", res_empty, 1);
    chk("read_len", got_q.size(), nexp);
    for (int i = 0; i < nexp && i < got_q.size(); i++)
      chk("read_order", got_q[i], m_arr[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t;
    bit seen;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_reset", s_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", res_empty, 1);
    chk("rst_count", res_count, 0);
    chk("rst_pblk", {p, pl, b, bl}, 0);
    chk("rst_flags", {activate, cmd_done, overflow, timeout}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_reset", s_reset, 0);

    m_arr = '{8'd3, 8'd9};
    run_search(8'd0, 8'd2, 8'd0, 8'd20, 0, 1'b0);

    for (int k = 0; k < 6; k++) begin
      fill_random($urandom_range(0, FD));
      run_search(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1, 1'b0);
    end

    fill_random(FD);
    run_search(8'h10, 8'h04, 8'h20, 8'h80, 0, 1'b0);
    fill_random(10);
    run_search(8'h11, 8'h05, 8'h21, 8'h81, 0, 1'b0);
    fill_random(6);
    run_search(8'h12, 8'h06, 8'h22, 8'h82, 2, 1'b0);
    fill_random(4);
    run_search(8'h13, 8'h07, 8'h23, 8'h83, 0, 1'b1);

    // Searcher that never answers: the wait limit must end the search.
    never_done = 1'b1;
    m_arr.delete();
    d0 = n_done; seen = 1'b0; t = 0;
    start_cmd(8'h01, 8'h02, 8'h03, 8'h04);
    for (int i = 0; i < 10; i++) begin
      if (activate) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("to_act_entered", seen, 1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      t++;
      if (cmd_done) begin seen = 1'b1; break; end
    end
    chk("to_cmd_done_seen", seen, 1);
    chk("to_latency_in_range", (t >= TO && t <= TO + 2) ? 1 : 0, 1);
    chk("to_timeout_flag", timeout, 1);
    @(negedge clk);
    chk("to_cmd_done_pulses", n_done - d0, 1);
    chk("to_overflow", overflow, 0);
    chk("to_count", res_count, 0);
    never_done = 1'b0;

    // Reset while waiting in the acknowledge phase.
    fill_random(5);
    d0 = n_done; seen = 1'b0;
    start_cmd(8'h40, 8'h02, 8'h50, 8'h30);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy && !activate && !cmd_done && !s_reset && res_count != 0) begin
        seen = 1'b1; break;
      end
    end
    chk("ack_reached", seen, 1);
    reset = 1'b1;
    #1;
    chk("ack_rst_s_reset", s_reset, 1);
    @(negedge clk);
    chk("ack_rst_busy", busy, 0);
    chk("ack_rst_count", res_count, 0);
    chk("ack_rst_empty", res_empty, 1);
    chk("ack_rst_activate", activate, 0);
    chk("ack_rst_b", b, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("ack_rst_no_cmd_done", n_done - d0, 0);
    chk("ack_rst_idle", busy, 0);

    fill_random(3);
    run_search(8'h7E, 8'h01, 8'h02, 8'h40, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
